// File: rtl/oam_dma.sv
// Sprite DMA engine sitting between the CPU core and the system bus.
// In IDLE the CPU bus is passed straight through. A CPU write to the
// trigger register stalls the CPU and copies one 256-byte page to the
// OAM data port as alternating READ (even cycle) / WRITE (odd cycle) pairs.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw,
    output logic        cpu_ready,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_rw,
    input  logic [7:0]  bus_rdata,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t     state;
    logic [7:0] idx;
    logic [7:0] page;
    logic [7:0] latch;
    logic       parity;
    logic       trig;

    // Trigger is only decoded while the CPU owns the bus.
    assign trig = (cpu_addr == DMA_REG_ADDR) && !cpu_rw;

    // busy is simply the inverse of the registered ready.
    assign busy = ~cpu_ready;

    // Transfer sequencer: state, counters, get/put parity, ready and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cpu_ready <= 1'b1;
            done      <= 1'b0;
            idx       <= 8'h00;
            page      <= 8'h00;
            latch     <= 8'h00;
            parity    <= 1'b0;
        end else begin
            parity <= ~parity;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        page      <= cpu_wdata;
                        idx       <= 8'h00;
                        state     <= HALT;
                        cpu_ready <= 1'b0;
                    end
                end
                HALT: begin
                    // Odd HALT means the next cycle is even: read right away.
                    state <= parity ? READ : ALIGN;
                end
                ALIGN: begin
                    state <= READ;
                end
                READ: begin
                    latch <= bus_rdata;
                    state <= WRITE;
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        state     <= IDLE;
                        cpu_ready <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        idx   <= idx + 8'h01;
                        state <= READ;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cpu_ready <= 1'b1;
                end
            endcase
        end
    end

    // Bus ownership mux: CPU pass-through in IDLE, engine drive otherwise.
    always_comb begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_rw    = cpu_rw;
        case (state)
            IDLE: begin
                bus_addr  = cpu_addr;
                bus_wdata = cpu_wdata;
                bus_rw    = cpu_rw;
            end
            HALT, ALIGN: begin
                // Dummy read cycles; the CPU address is left on the bus.
                bus_addr  = cpu_addr;
                bus_wdata = cpu_wdata;
                bus_rw    = 1'b1;
            end
            READ: begin
                bus_addr  = {page, idx};
                bus_wdata = latch;
                bus_rw    = 1'b1;
            end
            WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_wdata = latch;
                bus_rw    = 1'b0;
            end
            default: begin
                bus_addr  = cpu_addr;
                bus_wdata = cpu_wdata;
                bus_rw    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed/randomized bench for oam_dma. A flat memory image answers bus
// reads; expected transfer data, stall lengths and cycle parity come from
// the trigger cycle number and the memory contents.
module tb_oam_dma;

    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_DATA = 16'h2004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_rw = 1'b1;
    logic        cpu_ready;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rw;
    logic [7:0]  bus_rdata;
    logic        busy;
    logic        done;

    logic [7:0] mem [0:65535];
    int checks = 0;
    int errors = 0;
    int cyc;

    oam_dma dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rw   (cpu_rw),
        .cpu_ready(cpu_ready),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rw   (bus_rw),
        .bus_rdata(bus_rdata),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    assign bus_rdata = mem[bus_addr];

    // Cycle number since reset release; its LSB is the expected get/put parity.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic rw, input logic [7:0] wd);
        cpu_addr  = a;
        cpu_rw    = rw;
        cpu_wdata = wd;
    endtask

    // One IDLE cycle: bus must mirror the CPU, ready high, no done.
    task automatic idle_drive(input logic [15:0] a, input logic rw, input logic [7:0] wd);
        drive(a, rw, wd);
        #1;
        chk("pt_addr", bus_addr, a);
        chk("pt_rw", bus_rw, rw);
        chk("pt_wdata", bus_wdata, wd);
        chk("pt_ready", cpu_ready, 1'b1);
        chk("pt_busy", busy, 1'b0);
        chk("pt_done", done, 1'b0);
    endtask

    task automatic idle_rand();
        logic [15:0] a;
        logic        rw;
        a  = 16'($urandom);
        rw = 1'($urandom);
        if (a == DMA_REG) rw = 1'b1;
        idle_drive(a, rw, 8'($urandom));
    endtask

    // Trigger a DMA of page pg in the current cycle (after the HALT parity
    // wait if want_par >= 0) and follow it to completion or to an abort.
    task automatic dma(input logic [7:0] pg, input int want_par, input int abort_at, input bit junk);
        int t, len, stall, wr, rd;
        bit got_done;
        while (want_par >= 0 && ((cyc + 1) % 2) != want_par) begin
            idle_rand();
            @(negedge clk);
        end
        t = cyc;
        drive(DMA_REG, 1'b0, pg);
        #1;
        chk("trig_addr", bus_addr, DMA_REG);
        chk("trig_rw", bus_rw, 1'b0);
        chk("trig_wdata", bus_wdata, pg);
        chk("trig_ready", cpu_ready, 1'b1);
        len = (((t + 1) % 2) == 1) ? 513 : 514;
        stall = 0; wr = 0; rd = 0; got_done = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (junk && n == 5) drive(DMA_REG, 1'b0, ~pg);
            else                drive(16'h0000, 1'b1, 8'($urandom));
            #1;
            if (cpu_ready) begin
                got_done = done;
                break;
            end
            stall++;
            chk("busy_high", busy, 1'b1);
            chk("done_low", done, 1'b0);
            if (!bus_rw) begin
                chk("wr_addr", bus_addr, OAM_DATA);
                chk("wr_data", bus_wdata, mem[{pg, wr[7:0]}]);
                chk("wr_odd", cyc % 2, 1);
                wr++;
                if (abort_at > 0 && wr == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("abort_ready", cpu_ready, 1'b1);
                    chk("abort_busy", busy, 1'b0);
                    chk("abort_done", done, 1'b0);
                    chk("abort_pt_addr", bus_addr, cpu_addr);
                    chk("abort_pt_rw", bus_rw, cpu_rw);
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
            end else if (bus_addr[15:8] == pg) begin
                chk("rd_addr", bus_addr, {pg, rd[7:0]});
                chk("rd_even", cyc % 2, 0);
                rd++;
            end
        end
        chk("stall_len", stall, len);
        chk("n_writes", wr, 256);
        chk("n_reads", rd, 256);
        chk("done_pulse", got_done, 1'b1);
    endtask

    initial begin
        logic [7:0] pg;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

        // Reset state
        drive(16'h1234, 1'b1, 8'h77);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", cpu_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pt_addr", bus_addr, 16'h1234);
        @(negedge clk);
        rst_n = 1'b1;

        // Pass-through
        @(negedge clk); idle_drive(16'h8000, 1'b1, 8'($urandom));
        @(negedge clk); idle_drive(16'h0300, 1'b0, 8'h55);
        for (int i = 0; i < 4; i++) begin @(negedge clk); idle_rand(); end

        // HALT on odd cycle: 513-cycle stall
        @(negedge clk); dma(8'h02, 1, 0, 1'b0);
        @(negedge clk); idle_rand();

        // HALT on even cycle: extra ALIGN, 514-cycle stall
        @(negedge clk); dma(8'h02, 0, 0, 1'b0);
        @(negedge clk); idle_rand();

        // Boundary page FF, random alignment
        @(negedge clk); dma(8'hFF, int'($urandom % 2), 0, 1'b0);
        @(negedge clk); idle_rand();

        // Reset after the 100th write, then a full page-03 transfer
        @(negedge clk); dma(8'h03, -1, 100, 1'b0);
        @(negedge clk); idle_rand();
        @(negedge clk); dma(8'h03, -1, 0, 1'b0);

        // Back-to-back: retrigger in the done cycle, junk trigger while busy
        pg = 8'($urandom_range(5, 254));
        @(negedge clk); dma(pg, -1, 0, 1'b0);
        dma(8'h04, -1, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin @(negedge clk); idle_rand(); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
